// File: rtl/kds_ctrl.sv
// Load controller for a NB_GROUPS x 3-FIFO shifter: walks a one-hot group enable per accepted triplet, then offers a window.
// in_ready/window flags are registered and move one cycle after each decision. Triplets stall while the consumer holds window_ready low.
module kds_ctrl #(
  parameter  int NB_GROUPS = 12,
  parameter  int CNT_WIDTH = 16,
  localparam int PTR_W     = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] nb_loads,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NB_GROUPS-1:0] le_select,
  output logic [PTR_W-1:0]     group_ptr,
  output logic                 window_valid,
  output logic                 window_last,
  input  logic                 window_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CONS,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_nb_loads;
  logic [CNT_WIDTH-1:0] w_nb_loads_nxt;
  logic [CNT_WIDTH-1:0] r_load_cnt;
  logic [CNT_WIDTH-1:0] w_load_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [PTR_W-1:0]     r_group_ptr;
  logic [PTR_W-1:0]     w_group_ptr_nxt;
  logic                 r_in_ready;
  logic                 r_window_valid;
  logic                 w_window_valid_nxt;
  logic                 r_window_last;
  logic                 w_window_last_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_ptr_wrap;
  logic                 w_cnt_hit;

  // Abort and an exhausted count both veto the accept, so le_select can never fire in those cycles.
  assign w_accept   = in_valid && r_in_ready && !abort && (r_load_cnt != r_nb_loads);
  assign w_cnt_inc  = r_load_cnt + CNT_WIDTH'(1);
  assign w_ptr_wrap = (r_group_ptr == PTR_W'(NB_GROUPS - 1));
  assign w_cnt_hit  = (w_cnt_inc == r_nb_loads);

  assign le_select    = w_accept ? (NB_GROUPS'(1) << r_group_ptr) : '0;
  assign in_ready     = r_in_ready;
  assign group_ptr    = r_group_ptr;
  assign window_valid = r_window_valid;
  assign window_last  = r_window_last;
  assign busy         = r_busy;
  assign done         = r_done;

  always_comb begin
    w_state_nxt        = r_state;
    w_nb_loads_nxt     = r_nb_loads;
    w_load_cnt_nxt     = r_load_cnt;
    w_group_ptr_nxt    = r_group_ptr;
    w_window_valid_nxt = r_window_valid;
    w_window_last_nxt  = r_window_last;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nb_loads_nxt  = nb_loads;
          w_load_cnt_nxt  = '0;
          w_group_ptr_nxt = '0;
          w_state_nxt     = (nb_loads != '0) ? S_LOAD : S_FINISH;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_load_cnt_nxt  = w_cnt_inc;
          // The last triplet of a partial group still advances the pointer; it then stays put.
          w_group_ptr_nxt = w_ptr_wrap ? '0 : r_group_ptr + PTR_W'(1);
          if (w_ptr_wrap || w_cnt_hit) begin
            w_state_nxt        = S_WAIT_CONS;
            w_window_valid_nxt = 1'b1;
            w_window_last_nxt  = w_cnt_hit;
          end
        end
      end
      S_WAIT_CONS: begin
        if (window_ready) begin
          w_state_nxt        = r_window_last ? S_FINISH : S_LOAD;
          w_window_valid_nxt = 1'b0;
          w_window_last_nxt  = 1'b0;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt        = S_IDLE;
      w_load_cnt_nxt     = '0;
      w_group_ptr_nxt    = '0;
      w_window_valid_nxt = 1'b0;
      w_window_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state        <= S_IDLE;
      r_nb_loads     <= '0;
      r_load_cnt     <= '0;
      r_group_ptr    <= '0;
      r_in_ready     <= 1'b0;
      r_window_valid <= 1'b0;
      r_window_last  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_nb_loads     <= w_nb_loads_nxt;
      r_load_cnt     <= w_load_cnt_nxt;
      r_group_ptr    <= w_group_ptr_nxt;
      r_in_ready     <= (w_state_nxt == S_LOAD);
      r_window_valid <= w_window_valid_nxt;
      r_window_last  <= w_window_last_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (w_state_nxt == S_FINISH);
    end
  end

endmodule

// File: tb/tb_kds_ctrl.sv
// Directed bench for kds_ctrl: job walks, partial group, consumer stall, valid gaps, abort, reset, empty job.
// Cycle numbering inside run_job: the cycle in which start is driven is cycle 1.
module tb_kds_ctrl;

  logic        clk;
  logic        arst_n_in;
  logic        start;
  logic [15:0] nb_loads;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] le_select;
  logic [3:0]  group_ptr;
  logic        window_valid;
  logic        window_last;
  logic        window_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int o_sel, o_win, o_mask, o_done, o_done_cyc, o_rdy, o_ptr_at_done, o_hold;

  kds_ctrl #(.NB_GROUPS(12), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .start        (start),
    .nb_loads     (nb_loads),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .le_select    (le_select),
    .group_ptr    (group_ptr),
    .window_valid (window_valid),
    .window_last  (window_last),
    .window_ready (window_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_le_select"}, le_select, 0);
    chk({tag, "_group_ptr"}, group_ptr, 0);
    chk({tag, "_window_valid"}, window_valid, 0);
    chk({tag, "_window_last"}, window_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Called just after a rising edge with the controller idle; runs one job and gathers statistics.
  task automatic run_job(input logic [15:0] nb, input bit tog, input int hold_n, input int restart_cyc);
    int          hold;
    bit          prev_vld;
    logic        last_at_rise;
    logic [11:0] one;
    logic [11:0] exp_sel;
    one = 12'd1;
    o_sel = 0; o_win = 0; o_mask = 0; o_done = 0; o_done_cyc = 0;
    o_rdy = 0; o_ptr_at_done = 0; o_hold = 0;
    hold = hold_n; prev_vld = 0; last_at_rise = 0;
    start = 1'b1; nb_loads = nb; in_valid = 1'b1; window_ready = 1'b1; abort = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) begin
        start    = (cyc == restart_cyc);
        nb_loads = (cyc == restart_cyc) ? 16'd2 : nb;
        if (tog) in_valid = ~in_valid;
        if (window_valid && hold > 0) begin
          window_ready = 1'b0;
          hold--;
        end else begin
          window_ready = 1'b1;
        end
      end
      @(negedge clk);
      if (le_select != 0) begin
        exp_sel = one << (o_sel % 12);
        chk("le_order", le_select, exp_sel);
        o_sel++;
      end
      chk("le_gate", le_select != 0, in_valid && in_ready);
      if (window_valid && !prev_vld) begin
        last_at_rise = window_last;
        if (window_last) o_mask |= (1 << o_win);
        o_win++;
      end else if (window_valid) begin
        chk("win_last_stable", window_last, last_at_rise);
      end
      if (window_valid && !window_ready) begin
        o_hold++;
        chk("hold_in_ready", in_ready, 0);
        chk("hold_le_select", le_select, 0);
      end
      prev_vld = window_valid;
      if (in_ready) o_rdy++;
      if (done) begin
        o_done++;
        if (o_done == 1) begin
          o_done_cyc    = cyc;
          o_ptr_at_done = group_ptr;
        end
      end
      @(posedge clk);
      #1;
      if (o_done > 0 && cyc >= o_done_cyc + 2) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    window_ready = 1'b1;
  endtask

  initial begin
    arst_n_in = 1'b0; start = 1'b0; nb_loads = 16'd0; abort = 1'b0;
    in_valid = 1'b1; window_ready = 1'b1;

    // Reset state, checked before any clock edge.
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // 24 triplets: two full rounds, last flag only on the second window, done on cycle 28.
    run_job(16'd24, 0, 0, 0);
    chk("j24_sel", o_sel, 24);
    chk("j24_win", o_win, 2);
    chk("j24_lastmask", o_mask, 2);
    chk("j24_done", o_done, 1);
    chk("j24_done_cyc", o_done_cyc, 28);

    // Partial final group: bits 0..4, one last window, pointer parked at 5.
    run_job(16'd5, 0, 0, 0);
    chk("j5_sel", o_sel, 5);
    chk("j5_win", o_win, 1);
    chk("j5_lastmask", o_mask, 1);
    chk("j5_done", o_done, 1);
    chk("j5_ptr", o_ptr_at_done, 5);
    chk("j5_done_cyc", o_done_cyc, 8);

    // Consumer stalls the window for 10 cycles.
    run_job(16'd12, 0, 10, 0);
    chk("stall_sel", o_sel, 12);
    chk("stall_hold", o_hold, 10);
    chk("stall_lastmask", o_mask, 1);
    chk("stall_done", o_done, 1);
    chk("stall_done_cyc", o_done_cyc, 25);

    // in_valid alternating: accepts only on odd cycles, order unchanged.
    run_job(16'd12, 1, 0, 0);
    chk("tog_sel", o_sel, 12);
    chk("tog_lastmask", o_mask, 1);
    chk("tog_done", o_done, 1);
    chk("tog_done_cyc", o_done_cyc, 27);

    // Abort after 7 accepts.
    start = 1'b1; nb_loads = 16'd12; in_valid = 1'b1; window_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("abort_pre_ptr", group_ptr, 7);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cycle_le", le_select, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk_all_zero("after_abort");
    @(posedge clk);
    #1;
    run_job(16'd3, 0, 0, 0);
    chk("abort_new_sel", o_sel, 3);
    chk("abort_new_lastmask", o_mask, 1);
    chk("abort_new_done", o_done, 1);
    chk("abort_new_done_cyc", o_done_cyc, 6);

    // Asynchronous reset in the middle of LOAD.
    start = 1'b1; nb_loads = 16'd12; in_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", busy, 1);
    arst_n_in = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    run_job(16'd3, 0, 0, 0);
    chk("rst_new_sel", o_sel, 3);
    chk("rst_new_done", o_done, 1);
    chk("rst_new_done_cyc", o_done_cyc, 6);

    // Empty job: done one cycle after start, never ready.
    run_job(16'd0, 0, 0, 0);
    chk("empty_done", o_done, 1);
    chk("empty_done_cyc", o_done_cyc, 2);
    chk("empty_rdy", o_rdy, 0);
    chk("empty_sel", o_sel, 0);

    // A second start while busy (nb_loads=2) must not shorten the running job.
    run_job(16'd12, 0, 0, 3);
    chk("busy_start_sel", o_sel, 12);
    chk("busy_start_done", o_done, 1);
    chk("busy_start_done_cyc", o_done_cyc, 15);
    @(negedge clk);
    chk("busy_start_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
